systolic_ctrl: RTL and testbench
================================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for an N x N output-stationary systolic array of mac cells (one shared acc_en).
//  On start it clears the array, then runs K+2N-2 compute beats, stalling whenever the feeders
//  are not ready. It asserts the skewed per-row A and per-column B operand valids, then drains
//  one result row per handshake. Sits between the FFN layer scheduler and array + feed buffers.
// PARAMETERS
//  N      4    array dimension (rows = cols = N), >= 2
//  K_MAX  256  max reduction length per job
//  KW     $clog2(K_MAX+1)      width of k_len_i
//  CW     $clog2(K_MAX+2*N-1)  width of beat counter
// PORTS
//  clk          in   1      clock, rising edge
//  rstn         in   1      async active-low reset
//  start_i      in   1      job request, sampled in IDLE only
//  k_len_i      in   KW     reduction length, latched on accepted start; 0..K_MAX
//  abort_i      in   1      sync abort, any state
//  busy_o       out  1      high in every state except IDLE
//  done_o       out  1      1-cycle pulse at job completion
//  clr_o        out  1      array accumulator clear, 1 cycle
//  acc_en_o     out  1      to every mac acc_en
//  feed_rdy_i   in   1      feed buffers can supply this beat
//  beat_o       out  CW     current compute beat t (0-based)
//  a_vld_o      out  N      row i drives A[i][t-i] when set, else drives 0
//  b_vld_o      out  N      col j drives B[t-j][j] when set, else drives 0
//  res_valid_o  out  1      result row available
//  res_ready_i  in   1      downstream accepts result row
//  res_row_o    out  $clog2(N)  result row index being drained
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched k_len=0.
//  States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE: start_i=1 latches k_len_i, next state CLEAR. start_i in other states is ignored.
//  CLEAR: clr_o=1 for exactly 1 cycle; beat=0. Next state is FEED, or DRAIN if k_len==0.
//  FEED: acc_en_o = feed_rdy_i (combinational). The beat advances only when acc_en_o=1.
//   a_vld_o[i] = acc_en_o && (beat-i) in [0,k_len-1]; b_vld_o[j] is the same with j.
//   A beat with feed_rdy_i=0 holds beat_o and all vld bits are 0: mac registers freeze.
//   Last beat = k_len+2N-3. Leave for DRAIN on the accepted last beat.
//   Compute cycles with no stall = k_len+2N-2.
//  DRAIN: acc_en_o=0; res_valid_o=1; res_row_o starts at 0.
//   res_row_o increments on each valid&&ready. After row N-1 is accepted, next state is DONE.
//   res_row_o is stable while valid is high and ready is low.
//  DONE: done_o=1 for 1 cycle, then IDLE. busy_o drops in the same cycle IDLE is entered.
//  abort_i: next state IDLE from any state, without done_o.
//   acc_en_o, the vld bits and res_valid_o are forced 0 in the abort cycle.
//  abort_i and start_i together in IDLE: abort wins, no job starts.
//  k_len_i > K_MAX: clamp to K_MAX on latch.
//  Async reset mid-job: immediate return to IDLE reset values. The array must be cleared
//   by the next job's CLEAR.
// TESTING
//  1 N=4,k_len=3, feed_rdy=1, ready=1: clr at cycle1; acc_en high 9 cycles;
//    a_vld[3] set only at beats 3..5; 4 result rows; done at cycle 15.
//  2 Same job, feed_rdy low for beats 2 and 6 (2 cycles each): acc_en low 4 cycles,
//    beat_o holds, totals unchanged, done delayed by 4 cycles; array sum matches golden matmul.
//  3 k_len=0: CLEAR->DRAIN with no acc_en pulse; 4 rows of 0 drained; done.
//  4 res_ready toggling 1/0: each row is held while ready=0; rows 0..3 in order, none skipped.
//  5 abort at FEED beat 4, then start with k_len=2: no done for job1, clr precedes job2,
//    job2 results are correct.
//  6 start during DRAIN ignored; rstn low during FEED: all outputs 0 asynchronously;
//    k_len_i=300 is clamped to 256.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: one clear cycle, skewed
// compute beats that stall with the feeders, then a row-by-row result drain.
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX+1),
  parameter int CW    = $clog2(K_MAX+2*N-1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [KW-1:0]        k_len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 clr_o,
  output logic                 acc_en_o,
  input  logic                 feed_rdy_i,
  output logic [CW-1:0]        beat_o,
  output logic [N-1:0]         a_vld_o,
  output logic [N-1:0]         b_vld_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [$clog2(N)-1:0] res_row_o
);
  localparam int RW = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [KW-1:0] K_CLAMP  = KW'(K_MAX);
  localparam logic [CW-1:0] BEAT_OFS = CW'(2*N-3);

  logic [2:0]    state;
  logic [KW-1:0] k_len;
  logic [CW-1:0] beat;
  logic [RW-1:0] row;
  logic          last_beat, last_row, res_fire;

  assign busy_o      = state != S_IDLE;
  assign done_o      = state == S_DONE;
  assign clr_o       = state == S_CLEAR;
  assign acc_en_o    = (state == S_FEED) && feed_rdy_i && !abort_i;
  assign res_valid_o = (state == S_DRAIN) && !abort_i;
  assign res_fire    = res_valid_o && res_ready_i;
  assign last_beat   = beat == (CW'(k_len) + BEAT_OFS);
  assign last_row    = row == RW'(N-1);
  assign beat_o      = beat;
  assign res_row_o   = row;

  // Lane i carries operand index beat-i; rows and columns share the same skew.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CW-1:0] rel;
    assign rel        = beat - CW'(i);
    assign a_vld_o[i] = acc_en_o && (beat >= CW'(i)) && (rel < CW'(k_len));
    assign b_vld_o[i] = a_vld_o[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      k_len <= '0;
      beat  <= '0;
      row   <= '0;
    end else if (abort_i) begin
      state <= S_IDLE;
      beat  <= '0;
      row   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          state <= S_CLEAR;
          k_len <= (k_len_i > K_CLAMP) ? K_CLAMP : k_len_i;
        end
        S_CLEAR: begin
          beat  <= '0;
          row   <= '0;
          state <= (k_len == '0) ? S_DRAIN : S_FEED;
        end
        S_FEED: if (acc_en_o) begin
          if (last_beat) state <= S_DRAIN;
          else           beat  <= beat + 1'b1;
        end
        S_DRAIN: if (res_fire) begin
          if (last_row) state <= S_DONE;
          else          row   <= row + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: phase-level reference model checked every cycle, a
// behavioural mac array driven by the sequencer, and directed job scenarios.
module tb_systolic_ctrl;
  localparam int N = 4, K_MAX = 256;
  localparam int KW = $clog2(K_MAX+1), CW = $clog2(K_MAX+2*N-1), RW = $clog2(N);

  logic clk = 0, rstn = 0, start = 0, abort = 0, feed_rdy = 1, res_ready = 1;
  logic [KW-1:0] k_len = '0;
  logic busy, done, clr, acc_en, res_valid;
  logic [CW-1:0] beat;
  logic [N-1:0] a_vld, b_vld;
  logic [RW-1:0] res_row;

  systolic_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .k_len_i(k_len), .abort_i(abort),
    .busy_o(busy), .done_o(done), .clr_o(clr), .acc_en_o(acc_en), .feed_rdy_i(feed_rdy),
    .beat_o(beat), .a_vld_o(a_vld), .b_vld_o(b_vld), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .res_row_o(res_row)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, $signed(act), $signed(exp), cyc);
    end
  endtask

  // Operand generators and golden matmul
  function automatic int aval(input int i, input int m);
    return (i*7 + m*3) % 11 - 5;
  endfunction
  function automatic int bval(input int m, input int j);
    return (m*5 + j*2) % 9 - 4;
  endfunction
  function automatic int golden(input int i, input int j, input int k);
    int s = 0;
    for (int m = 0; m < k; m++) s += aval(i, m) * bval(m, j);
    return s;
  endfunction

  // Phase-level model: 0 idle, 1 clear, 2 feed, 3 drain, 4 done
  int m_ph = 0, m_beat = 0, m_k = 0, m_row = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph <= 0; m_beat <= 0; m_k <= 0; m_row <= 0;
    end else if (abort) m_ph <= 0;
    else case (m_ph)
      0: if (start) begin m_ph <= 1; m_k <= (int'(k_len) > K_MAX) ? K_MAX : int'(k_len); end
      1: begin m_beat <= 0; m_row <= 0; m_ph <= (m_k == 0) ? 3 : 2; end
      2: if (feed_rdy) begin
           if (m_beat == m_k + 2*N - 3) m_ph <= 3; else m_beat <= m_beat + 1;
         end
      3: if (res_ready) begin
           if (m_row == N-1) m_ph <= 4; else m_row <= m_row + 1;
         end
      default: m_ph <= 0;
    endcase
  end

  function automatic logic [N-1:0] exp_vld(input logic en, input int b, input int k);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = en && (b - i >= 0) && (b - i < k);
    return v;
  endfunction

  // Tallies and behavioural mac array
  int t0 = 0, done_cyc = -1, clr_cyc = -1, first_acc = -1;
  int clr_cnt = 0, acc_cnt = 0, stall_cnt = 0, done_cnt = 0;
  int a3_q[$], row_q[$];
  int acc[N][N], a_reg[N][N], b_reg[N][N], ca[N][N], cb[N][N];
  int ain[N], bin[N];

  always @(negedge clk) begin : compare
    logic e_acc;
    e_acc = (m_ph == 2) && feed_rdy && !abort;
    chk("busy", busy, m_ph != 0);
    chk("done", done, m_ph == 4);
    chk("clr", clr, m_ph == 1);
    chk("acc_en", acc_en, e_acc);
    chk("a_vld", a_vld, exp_vld(e_acc, m_beat, m_k));
    chk("b_vld", b_vld, exp_vld(e_acc, m_beat, m_k));
    chk("res_valid", res_valid, (m_ph == 3) && !abort);
    if (m_ph == 2) chk("beat", beat, m_beat);
    if (m_ph == 3) chk("res_row", res_row, m_row);

    if (done) begin done_cnt++; done_cyc = cyc - t0; end
    if (clr) begin clr_cnt++; clr_cyc = cyc - t0; end
    if (m_ph == 2 && !acc_en) stall_cnt++;
    if (res_valid && res_ready) row_q.push_back(int'(res_row));
    if (acc_en) begin
      if (acc_cnt == 0) first_acc = cyc - t0;
      acc_cnt++;
      if (a_vld[3]) a3_q.push_back(int'(beat));
    end

    if (clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin acc[i][j] = 0; a_reg[i][j] = 0; b_reg[i][j] = 0; end
    end else if (acc_en) begin
      for (int i = 0; i < N; i++) begin
        ain[i] = a_vld[i] ? aval(i, int'(beat) - i) : 0;
        bin[i] = b_vld[i] ? bval(int'(beat) - i, i) : 0;
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ca[i][j] = (j == 0) ? ain[i] : a_reg[i][j-1];
          cb[i][j] = (i == 0) ? bin[j] : b_reg[i-1][j];
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] += ca[i][j] * cb[i][j];
          a_reg[i][j] = ca[i][j];
          b_reg[i][j] = cb[i][j];
        end
    end
  end

  // Stimulus helpers
  int  stall_left[int];
  bit  toggle_ready = 0, start_in_drain = 0;

  task automatic step();
    @(posedge clk); #1;
    start = start_in_drain && (m_ph == 3);
    feed_rdy = 1;
    if (m_ph == 2 && stall_left.exists(m_beat) && stall_left[m_beat] > 0) begin
      feed_rdy = 0;
      stall_left[m_beat]--;
    end
    if (toggle_ready) res_ready = ~res_ready;
  endtask

  task automatic clear_tally();
    done_cyc = -1; clr_cyc = -1; first_acc = -1;
    clr_cnt = 0; acc_cnt = 0; stall_cnt = 0; done_cnt = 0;
    a3_q.delete(); row_q.delete();
  endtask

  task automatic run_job(input int k, input bit tog);
    clear_tally();
    start = 1; k_len = KW'(k); t0 = cyc;
    toggle_ready = tog; res_ready = !tog;
    step();
    for (int n = 0; n < 2000 && done_cnt == 0; n++) step();
    chk("job_done_seen", done_cnt, 1);
    toggle_ready = 0; res_ready = 1;
    step();
  endtask

  task automatic check_array(input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("acc[%0d][%0d]", i, j), acc[i][j], golden(i, j, k));
  endtask

  task automatic check_rows();
    chk("rows_n", row_q.size(), N);
    for (int r = 0; r < row_q.size() && r < N; r++) chk($sformatf("row_order%0d", r), row_q[r], r);
  endtask

  task automatic goto_beat(input int b);
    int n = 0;
    while (!(m_ph == 2 && m_beat == b) && n < 50) begin step(); n++; end
    chk("reach_beat", m_beat, b);
  endtask

  initial begin : stim
    int exp3[3];
    exp3 = '{3, 4, 5};
    #3;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_clr", clr, 0);
    chk("rst_acc_en", acc_en, 0); chk("rst_beat", beat, 0); chk("rst_a_vld", a_vld, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_res_row", res_row, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    step();

    // 1: plain k=3 job
    run_job(3, 0);
    chk("t1_clr_cyc", clr_cyc, 1); chk("t1_clr_cnt", clr_cnt, 1);
    chk("t1_acc_cnt", acc_cnt, 9); chk("t1_done_cyc", done_cyc, 15);
    chk("t1_a3_n", a3_q.size(), 3);
    for (int i = 0; i < a3_q.size() && i < 3; i++) chk("t1_a3_beat", a3_q[i], exp3[i]);
    check_rows();
    check_array(3);

    // 2: feeder stalls at beats 2 and 6, two cycles each
    stall_left[2] = 2; stall_left[6] = 2;
    run_job(3, 0);
    chk("t2_acc_cnt", acc_cnt, 9); chk("t2_stall_cnt", stall_cnt, 4);
    chk("t2_done_cyc", done_cyc, 19);
    check_array(3);

    // 3: k=0 goes straight to drain
    run_job(0, 0);
    chk("t3_acc_cnt", acc_cnt, 0); chk("t3_done_cyc", done_cyc, 6);
    check_rows();
    check_array(0);

    // 4: toggling downstream ready
    run_job(1, 1);
    check_rows();
    chk("t4_done_cyc", done_cyc, 16);
    check_array(1);

    // abort and start together in idle: abort wins
    start = 1; abort = 1; k_len = 3;
    step();
    abort = 0;
    chk("abort_wins_busy", busy, 0);

    // 5: abort at feed beat 4, then k=2 job
    clear_tally();
    start = 1; k_len = 3; t0 = cyc;
    step();
    goto_beat(4);
    abort = 1;
    step();
    abort = 0;
    repeat (3) step();
    chk("t5_no_done", done_cnt, 0); chk("t5_idle", busy, 0);
    run_job(2, 0);
    chk("t5_clr_cyc", clr_cyc, 1); chk("t5_first_acc", first_acc, 2);
    chk("t5_acc_cnt", acc_cnt, 8); chk("t5_done_cyc", done_cyc, 14);
    check_array(2);

    // 6a: start held during drain is ignored
    start_in_drain = 1;
    run_job(1, 0);
    start_in_drain = 0;
    chk("t6_done_cyc", done_cyc, 13);
    repeat (2) step();
    chk("t6_drain_start_ignored", busy, 0);

    // 6b: async reset mid-feed
    clear_tally();
    start = 1; k_len = 3; t0 = cyc;
    step();
    goto_beat(3);
    #2 rstn = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_acc_en", acc_en, 0); chk("arst_beat", beat, 0);
    chk("arst_a_vld", a_vld, 0); chk("arst_b_vld", b_vld, 0); chk("arst_clr", clr, 0);
    chk("arst_done", done, 0); chk("arst_res_valid", res_valid, 0); chk("arst_res_row", res_row, 0);
    @(posedge clk);
    #1 rstn = 1;
    step();

    // 6c: k_len above K_MAX clamps
    run_job(300, 0);
    chk("t6_clamp_acc_cnt", acc_cnt, 262); chk("t6_clamp_done_cyc", done_cyc, 268);
    check_array(256);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
